// File: rtl/store_commit_buffer.sv
// Committed-store FIFO between ROB retirement and the data memory write port.
// Loads probe all queued stores: exact covering matches forward, partial overlaps request replay.
module store_commit_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic [2:0]       commit_funct3,
  input  logic [31:0]      commit_addr,
  input  logic [31:0]      commit_data,
  output logic             commit_ready,
  input  logic             mem_stall,
  output logic             mem_write,
  output logic [31:0]      mem_addr,
  output logic [2:0]       mem_funct3,
  output logic [31:0]      mem_data,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [2:0]       ld_funct3,
  output logic             ld_hit,
  output logic [31:0]      ld_data,
  output logic             ld_conflict,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      addr_mem [DEPTH];
  logic [2:0]       f3_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [PTR_W:0]   count_reg;
  logic             commit_ok, enq, deq;

  function automatic logic [2:0] st_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   st_size = 3'd1;
      2'b01:   st_size = 3'd2;
      default: st_size = 3'd4;
    endcase
  endfunction

  assign commit_ok    = (commit_funct3 == 3'b000) || (commit_funct3 == 3'b001) ||
                        (commit_funct3 == 3'b010);
  assign empty        = (count_reg == '0);
  assign count        = count_reg;
  assign commit_ready = (count_reg != FULL_CNT);
  assign enq          = commit_valid && commit_ready && commit_ok;
  assign mem_write    = !empty && !mem_stall;
  assign deq          = mem_write;

  assign mem_addr   = empty ? 32'd0 : addr_mem[head_reg];
  assign mem_funct3 = empty ? 3'd0  : f3_mem[head_reg];
  assign mem_data   = empty ? 32'd0 : data_mem[head_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enq) tail_reg <= tail_reg + PTR_W'(1);
      if (deq) head_reg <= head_reg + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail_reg] <= commit_addr;
      f3_mem[tail_reg]   <= commit_funct3;
      data_mem[tail_reg] <= commit_data;
    end
  end

  logic             ld_ok;
  logic [2:0]       ld_m;
  logic [32:0]      ld_end;
  logic [DEPTH-1:0] ov_vec, ex_vec;

  always_comb begin
    ld_ok = 1'b1;
    ld_m  = 3'd4;
    case (ld_funct3)
      3'b000, 3'b100: ld_m = 3'd1;
      3'b001, 3'b101: ld_m = 3'd2;
      3'b010:         ld_m = 3'd4;
      default:        ld_ok = 1'b0;
    endcase
  end

  assign ld_end = {1'b0, ld_addr} + {30'd0, ld_m};

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] age;
      logic             live;
      logic [2:0]       st_n;
      logic [32:0]      st_end;

      assign age    = PTR_W'(gi) - head_reg;
      assign live   = ({1'b0, age} < count_reg);
      assign st_n   = st_size(f3_mem[gi]);
      assign st_end = {1'b0, addr_mem[gi]} + {30'd0, st_n};
      assign ov_vec[gi] = live && ld_ok && ({1'b0, addr_mem[gi]} < ld_end) &&
                          ({1'b0, ld_addr} < st_end);
      assign ex_vec[gi] = (addr_mem[gi] == ld_addr) && (st_n >= ld_m);
    end
  endgenerate

  logic             found, sel_exact;
  logic [31:0]      sel_data;
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last overlapping entry seen wins.
  always_comb begin
    found     = 1'b0;
    sel_exact = 1'b0;
    sel_data  = 32'd0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_reg + PTR_W'(k);
      if (ov_vec[idx]) begin
        found     = 1'b1;
        sel_exact = ex_vec[idx];
        sel_data  = data_mem[idx];
      end
    end
  end

  always_comb begin
    ld_hit      = ld_valid && found && sel_exact;
    ld_conflict = ld_valid && found && !sel_exact;
    ld_data     = 32'd0;
    if (ld_hit) begin
      case (ld_funct3)
        3'b000:  ld_data = {{24{sel_data[7]}}, sel_data[7:0]};
        3'b001:  ld_data = {{16{sel_data[15]}}, sel_data[15:0]};
        3'b100:  ld_data = {24'd0, sel_data[7:0]};
        3'b101:  ld_data = {16'd0, sel_data[15:0]};
        default: ld_data = sel_data;
      endcase
    end
  end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: directed scenarios plus a randomized run
// compared against a queue-based model of the store buffer.
module tb_store_commit_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 0, reset = 0;
  logic commit_valid = 0, mem_stall = 0, ld_valid = 0;
  logic [2:0] commit_funct3 = 0, ld_funct3 = 0;
  logic [31:0] commit_addr = 0, commit_data = 0, ld_addr = 0;
  logic commit_ready, mem_write, ld_hit, ld_conflict, empty;
  logic [31:0] mem_addr, mem_data, ld_data;
  logic [2:0] mem_funct3;
  logic [PTR_W:0] count;

  int checks = 0, errors = 0;

  typedef struct { logic [31:0] a; logic [2:0] f; logic [31:0] d; } ent_t;
  ent_t ref_q[$];

  store_commit_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_funct3(commit_funct3),
    .commit_addr(commit_addr), .commit_data(commit_data), .commit_ready(commit_ready),
    .mem_stall(mem_stall), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_funct3(mem_funct3), .mem_data(mem_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Model of the load probe: search youngest to oldest for the first overlapping store.
  function automatic void ref_lookup(input logic [31:0] la, input logic [2:0] lf,
                                     output bit hit, output bit conf, output logic [31:0] data);
    int m;
    hit = 0; conf = 0; data = 0;
    case (lf)
      3'd0, 3'd4: m = 1;
      3'd1, 3'd5: m = 2;
      3'd2:       m = 4;
      default:    return;
    endcase
    for (int i = ref_q.size() - 1; i >= 0; i--) begin
      int n;
      longint sa, l;
      logic [31:0] dd;
      n  = (ref_q[i].f == 3'd0) ? 1 : (ref_q[i].f == 3'd1) ? 2 : 4;
      sa = longint'(ref_q[i].a);
      l  = longint'(la);
      dd = ref_q[i].d;
      if (sa < l + m && l < sa + n) begin
        if (sa == l && n >= m) begin
          hit = 1;
          case (lf)
            3'd0: data = 32'(int'(dd[7:0]) - (dd[7] ? 256 : 0));
            3'd1: data = 32'(int'(dd[15:0]) - (dd[15] ? 65536 : 0));
            3'd4: data = dd % 256;
            3'd5: data = dd % 65536;
            default: data = dd;
          endcase
        end else begin
          conf = 1;
        end
        return;
      end
    end
  endfunction

  // One clock edge with the model updated from the inputs presented in this cycle.
  task automatic step();
    bit acc, deq;
    acc = commit_valid && ref_q.size() < DEPTH && (commit_funct3 inside {3'd0, 3'd1, 3'd2});
    deq = ref_q.size() > 0 && !mem_stall;
    if (commit_valid && ref_q.size() == DEPTH)
      $display("note: protocol error, commit_valid while full at %0t (ignored)", $time);
    @(posedge clk);
    if (deq) void'(ref_q.pop_front());
    if (acc) ref_q.push_back('{commit_addr, commit_funct3, commit_data});
    #1;
    commit_valid = 0;
    #1;
  endtask

  task automatic do_commit(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    commit_valid = 1; commit_funct3 = f; commit_addr = a; commit_data = d;
    $display("commit f3=%0d addr=%h data=%h", f, a, d);
    step();
  endtask

  task automatic test_reset();
    reset = 0; #13;
    checks++; if (commit_ready !== 1'b1 || empty !== 1'b1 || count !== 3'd0) begin
      errors++; $display("FAIL reset_flags ready=%b empty=%b count=%0d exp 1 1 0", commit_ready, empty, count); end
    checks++; if (mem_write !== 1'b0 || ld_hit !== 1'b0 || ld_conflict !== 1'b0) begin
      errors++; $display("FAIL reset_strobes mw=%b hit=%b conf=%b exp 0 0 0", mem_write, ld_hit, ld_conflict); end
    checks++; if (mem_addr !== 0 || mem_data !== 0 || mem_funct3 !== 0 || ld_data !== 0) begin
      errors++; $display("FAIL reset_data addr=%h data=%h f3=%0d ld=%h exp 0", mem_addr, mem_data, mem_funct3, ld_data); end
    @(negedge clk); reset = 1;
    @(posedge clk); #2;
  endtask

  task automatic test_basic();
    mem_stall = 0;
    commit_valid = 1; commit_funct3 = 3'b010; commit_addr = 32'h100; commit_data = 32'hDEADBEEF;
    #1;
    checks++; if (mem_write !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL basic_no_bypass mw=%b empty=%b exp 0 1", mem_write, empty); end
    step();
    checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h100 || mem_funct3 !== 3'b010 || mem_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_drain mw=%b addr=%h f3=%0d data=%h exp 1 100 2 deadbeef", mem_write, mem_addr, mem_funct3, mem_data); end
    step();
    checks++; if (empty !== 1'b1 || mem_write !== 1'b0) begin
      errors++; $display("FAIL basic_empty empty=%b mw=%b exp 1 0", empty, mem_write); end
  endtask

  task automatic test_full();
    mem_stall = 1;
    for (int i = 0; i < 4; i++) do_commit(3'b010, 32'(i * 4), 32'hA000_0000 + 32'(i));
    checks++; if (count !== 3'd4 || commit_ready !== 1'b0) begin
      errors++; $display("FAIL full_state count=%0d ready=%b exp 4 0", count, commit_ready); end
    commit_valid = 1; commit_funct3 = 3'b010; commit_addr = 32'h10; commit_data = 32'h5555_5555;
    mem_stall = 0; #1;
    checks++; if (commit_ready !== 1'b0 || mem_write !== 1'b1) begin
      errors++; $display("FAIL full_release ready=%b mw=%b exp 0 1", commit_ready, mem_write); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_write !== 1'b1 || mem_addr !== 32'(i * 4) || mem_data !== 32'hA000_0000 + 32'(i)) begin
        errors++; $display("FAIL full_order[%0d] mw=%b addr=%h data=%h exp 1 %h %h", i, mem_write, mem_addr, mem_data, i * 4, 32'hA000_0000 + 32'(i)); end
      $display("drain addr=%h data=%h", mem_addr, mem_data);
      step();
    end
    checks++; if (count !== 3'd0 || empty !== 1'b1 || mem_write !== 1'b0) begin
      errors++; $display("FAIL full_drained count=%0d empty=%b mw=%b exp 0 1 0", count, empty, mem_write); end
  endtask

  task automatic test_forward();
    mem_stall = 1;
    do_commit(3'b000, 32'h20, 32'h0000_0080);
    ld_valid = 1; ld_addr = 32'h20; ld_funct3 = 3'b000; #1;
    checks++; if (ld_hit !== 1'b1 || ld_conflict !== 1'b0 || ld_data !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL fwd_lb hit=%b conf=%b data=%h exp 1 0 ffffff80", ld_hit, ld_conflict, ld_data); end
    ld_funct3 = 3'b100; #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h0000_0080) begin
      errors++; $display("FAIL fwd_lbu hit=%b data=%h exp 1 00000080", ld_hit, ld_data); end
    ld_valid = 0;
    do_commit(3'b010, 32'h40, 32'h1111_1111);
    do_commit(3'b010, 32'h40, 32'h2222_3344);
    ld_valid = 1; ld_addr = 32'h40; ld_funct3 = 3'b001; #1;
    checks++; if (ld_hit !== 1'b1 || ld_conflict !== 1'b0 || ld_data !== 32'h0000_3344) begin
      errors++; $display("FAIL fwd_youngest hit=%b conf=%b data=%h exp 1 0 00003344", ld_hit, ld_conflict, ld_data); end
    ld_valid = 0;
    do_commit(3'b000, 32'h41, 32'h55);
    ld_valid = 1; ld_addr = 32'h40; ld_funct3 = 3'b010; #1;
    checks++; if (ld_hit !== 1'b0 || ld_conflict !== 1'b1) begin
      errors++; $display("FAIL fwd_conflict hit=%b conf=%b exp 0 1", ld_hit, ld_conflict); end
    ld_addr = 32'h44; ld_funct3 = 3'b000; #1;
    checks++; if (ld_hit !== 1'b0 || ld_conflict !== 1'b0 || ld_data !== 32'd0) begin
      errors++; $display("FAIL fwd_miss hit=%b conf=%b data=%h exp 0 0 0", ld_hit, ld_conflict, ld_data); end
    ld_addr = 32'h20; ld_funct3 = 3'b000; mem_stall = 0; #1;
    checks++; if (ld_hit !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 32'h20) begin
      errors++; $display("FAIL fwd_head_draining hit=%b mw=%b addr=%h exp 1 1 20", ld_hit, mem_write, mem_addr); end
    ld_valid = 0; #1;
    checks++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin
      errors++; $display("FAIL fwd_ld_invalid hit=%b data=%h exp 0 0", ld_hit, ld_data); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (empty !== 1'b1) begin
      errors++; $display("FAIL fwd_drained empty=%b exp 1", empty); end
  endtask

  task automatic test_async_reset();
    mem_stall = 1;
    for (int i = 0; i < 3; i++) do_commit(3'b010, 32'h300 + 32'(i * 4), 32'(i));
    mem_stall = 0; #1;
    reset = 0; #1;
    ref_q.delete();
    checks++; if (count !== 3'd0 || mem_write !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL async_reset count=%0d mw=%b empty=%b exp 0 0 1", count, mem_write, empty); end
    @(posedge clk); #3; reset = 1; #1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (mem_write !== 1'b0) begin
        errors++; $display("FAIL async_no_write[%0d] mw=%b exp 0", i, mem_write); end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit eh, ec;
      logic [31:0] ed;
      commit_valid  = ($urandom_range(0, 1) == 1);
      commit_funct3 = ($urandom_range(0, 9) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
      commit_addr   = 32'h200 + $urandom_range(0, 11);
      commit_data   = $urandom;
      mem_stall     = ($urandom_range(0, 9) < 4);
      ld_valid      = ($urandom_range(0, 3) != 0);
      ld_addr       = 32'h200 + $urandom_range(0, 11);
      ld_funct3     = 3'($urandom_range(0, 7));
      #1;
      checks++; if (count !== 3'(ref_q.size()) || commit_ready !== (ref_q.size() != DEPTH) || empty !== (ref_q.size() == 0)) begin
        errors++; $display("FAIL rnd_occupancy[%0d] count=%0d ready=%b empty=%b exp count %0d", cyc, count, commit_ready, empty, ref_q.size()); end
      if (ref_q.size() > 0) begin
        checks++; if (mem_write !== !mem_stall || mem_addr !== ref_q[0].a || mem_funct3 !== ref_q[0].f || mem_data !== ref_q[0].d) begin
          errors++; $display("FAIL rnd_head[%0d] mw=%b addr=%h f3=%0d data=%h exp %b %h %0d %h", cyc, mem_write, mem_addr, mem_funct3, mem_data, !mem_stall, ref_q[0].a, ref_q[0].f, ref_q[0].d); end
        if (!mem_stall) $display("txn %0d drain addr=%h data=%h", cyc, mem_addr, mem_data);
      end else begin
        checks++; if (mem_write !== 1'b0 || mem_addr !== 0 || mem_data !== 0 || mem_funct3 !== 0) begin
          errors++; $display("FAIL rnd_idle[%0d] mw=%b addr=%h data=%h f3=%0d exp 0", cyc, mem_write, mem_addr, mem_data, mem_funct3); end
      end
      if (ld_valid) ref_lookup(ld_addr, ld_funct3, eh, ec, ed);
      else begin eh = 0; ec = 0; ed = 0; end
      checks++; if (ld_hit !== eh || ld_conflict !== ec || (!ec && ld_data !== ed)) begin
        errors++; $display("FAIL rnd_lookup[%0d] la=%h lf=%0d hit=%b conf=%b data=%h exp %b %b %h", cyc, ld_addr, ld_funct3, ld_hit, ld_conflict, ld_data, eh, ec, ed); end
      step();
    end
    ld_valid = 0; mem_stall = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_forward();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
